// File: rtl/mant_fsm_ctrl_param_if.sv
// Status/control bundle between the board top level and the maintenance-aware controller.
// Latency: none; it is plain wiring.
// Backpressure: none; inputs are levels or pulses, and the outputs are always valid.
interface mant_fsm_ctrl_param_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mant;
  logic             clr_cnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] state_out;
  logic             busy;
  logic             done;
  logic             in_mant;
  logic             cnt_sat;

  // Board side: it issues requests and observes status.
  modport master (
    output start, mant, clr_cnt, sel,
    input  state_out, busy, done, in_mant, cnt_sat
  );

  // Controller side.
  modport slave (
    input  start, mant, clr_cnt, sel,
    output state_out, busy, done, in_mant, cnt_sat
  );
endinterface

// File: rtl/mant_fsm_ctrl_param.sv
// Process controller with a run timer, a maintenance FSM, saturating event counters and a selectable status bus.
// Latency: flags decode the registered state with no extra lag; state_out lags the internal registers by one cycle.
// Backpressure: none; start is honoured only in IDLE and is otherwise dropped, never queued.
module mant_fsm_ctrl_param #(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 10,
  parameter int MANT_MIN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mant_fsm_ctrl_param_if.slave   bus
);

  // The timer must be able to hold the longer of the two dwell limits.
  localparam int TLIM = (TIMEOUT > MANT_MIN) ? TIMEOUT : MANT_MIN;
  localparam int TW   = $clog2(TLIM + 1);

  // The mux width covers every source and the output, so a cast zero-extends and a slice truncates.
  localparam int XW0 = (WIDTH > CNT_W) ? WIDTH : CNT_W;
  localparam int XW1 = (XW0 > TW) ? XW0 : TW;
  localparam int XW  = (XW1 > 2) ? XW1 : 2;

  localparam logic [TW-1:0]    TMR_MAX   = '1;
  localparam logic [TW-1:0]    RUN_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]    MANT_LAST = TW'(MANT_MIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // These codes appear directly on state_out when sel selects the state.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_MANT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] mant_cnt_q, mant_cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [WIDTH-1:0] state_out_q, state_out_d;
  logic             mant_inc;
  logic             run_inc;
  logic [XW-1:0]    stat_src;

  // Next state and timer. A maintenance request from any state except MANT pre-empts the state-specific rules.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    mant_inc = 1'b0;
    run_inc  = 1'b0;
    if (bus.mant && (state_q != S_MANT)) begin
      // An interrupted run is abandoned: the timer is cleared and the run is not counted.
      state_d  = S_MANT;
      timer_d  = '0;
      mant_inc = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_RUN;
            timer_d = '0;
          end
        end
        S_RUN: begin
          if (timer_q == RUN_LAST) begin
            state_d = S_DONE;
            timer_d = '0;
            run_inc = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        S_MANT: begin
          if (!bus.mant && (timer_q >= MANT_LAST)) begin
            state_d = S_IDLE;
            timer_d = '0;
          end else if (timer_q != TMR_MAX) begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Saturating event counters. A clear wins over an increment in the same cycle.
  always_comb begin
    mant_cnt_d = mant_cnt_q;
    run_cnt_d  = run_cnt_q;
    if (bus.clr_cnt) begin
      mant_cnt_d = '0;
      run_cnt_d  = '0;
    end else begin
      if (mant_inc && (mant_cnt_q != CNT_MAX)) begin
        mant_cnt_d = mant_cnt_q + 1'b1;
      end
      if (run_inc && (run_cnt_q != CNT_MAX)) begin
        run_cnt_d = run_cnt_q + 1'b1;
      end
    end
  end

  // Status selector. It reads the current registers, so the registered bus lags them by one cycle.
  always_comb begin
    stat_src = '0;
    case (bus.sel)
      2'd0:    stat_src = XW'(state_q);
      2'd1:    stat_src = XW'(mant_cnt_q);
      2'd2:    stat_src = XW'(timer_q);
      default: stat_src = XW'(run_cnt_q);
    endcase
    state_out_d = stat_src[WIDTH-1:0];
  end

  // State, timer, counters and status bus. A synchronous reset overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      mant_cnt_q  <= '0;
      run_cnt_q   <= '0;
      state_out_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mant_cnt_q  <= mant_cnt_d;
      run_cnt_q   <= run_cnt_d;
      state_out_q <= state_out_d;
    end
  end

  assign bus.state_out = state_out_q;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.in_mant   = (state_q == S_MANT);
  assign bus.cnt_sat   = (mant_cnt_q == CNT_MAX);

endmodule
